// File: rtl/clock_lane_fsm.sv
// MIPI D-PHY clock-lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> HS-pre -> HS
// -> HS-post -> HS-trail, with continuous-clock mode and ULPS entry/exit.
module clock_lane_fsm #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned LPX_CYC   = 1,
    parameter int unsigned ZERO_CYC  = 8,
    parameter int unsigned PRE_CYC   = 8,
    parameter int unsigned POST_CYC  = 8,
    parameter int unsigned TRAIL_CYC = 8,
    parameter int unsigned WAKE_CYC  = 1000
) (
    input  logic byte_clk,
    input  logic byte_rst,
    input  logic hs_req,
    input  logic enable,
    input  logic cont_clk,
    input  logic ulps_req,
    output logic lp_p,
    output logic lp_n,
    output logic ser_hi_z,
    output logic ser_enable,
    output logic hs_rdy,
    output logic lane_idle,
    output logic ulps_active
);

    typedef enum logic [3:0] {
        S_LP11, S_LP01, S_LP00, S_ZERO, S_PRE, S_HS,
        S_POST, S_TRAIL, S_ULPS_ENT, S_ULPS, S_WAKE
    } state_e;

    // Terminal count of each timed phase: a phase of N cycles exits at cnt == N-1.
    localparam logic [CNT_W-1:0] LPX_LAST   = CNT_W'(LPX_CYC - 1);
    localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(ZERO_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(POST_CYC - 1);
    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] phase_last;
    logic             timed;
    logic             phase_done;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        timed      = 1'b1;
        phase_last = '0;
        case (state_q)
            S_LP01, S_LP00, S_ULPS_ENT: phase_last = LPX_LAST;
            S_ZERO:                     phase_last = ZERO_LAST;
            S_PRE:                      phase_last = PRE_LAST;
            S_POST:                     phase_last = POST_LAST;
            S_TRAIL:                    phase_last = TRAIL_LAST;
            S_WAKE:                     phase_last = WAKE_LAST;
            default:                    timed      = 1'b0;
        endcase
    end

    assign phase_done = timed && (cnt_q == phase_last);

    // Inputs are only looked at in the decision states LP11, HS and ULPS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LP11: begin
                if (hs_req || cont_clk) state_d = S_LP01;
                else if (ulps_req)      state_d = S_ULPS_ENT;
            end
            S_LP01:     if (phase_done) state_d = S_LP00;
            S_LP00:     if (phase_done) state_d = S_ZERO;
            S_ZERO:     if (phase_done) state_d = S_PRE;
            S_PRE:      if (phase_done) state_d = S_HS;
            S_HS:       if (!hs_req && !cont_clk) state_d = S_POST;
            S_POST:     if (phase_done) state_d = S_TRAIL;
            S_TRAIL:    if (phase_done) state_d = S_LP11;
            S_ULPS_ENT: if (phase_done) state_d = S_ULPS;
            S_ULPS:     if (!ulps_req) state_d = S_WAKE;
            S_WAKE:     if (phase_done) state_d = S_LP11;
            default:    state_d = S_LP11;
        endcase
    end

    // Counter clears on every state change and holds at its terminal value, so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (timed && !phase_done)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge byte_clk or posedge byte_rst) begin
        if (byte_rst) begin
            state_q <= S_LP11;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode of the registered state; only HS gating looks at live inputs.
    always_comb begin
        lp_p        = 1'b0;
        lp_n        = 1'b0;
        ser_hi_z    = 1'b0;
        ser_enable  = 1'b0;
        hs_rdy      = 1'b0;
        lane_idle   = 1'b0;
        ulps_active = 1'b0;
        case (state_q)
            S_LP11: begin
                lp_p      = 1'b1;
                lp_n      = 1'b1;
                ser_hi_z  = 1'b1;
                lane_idle = 1'b1;
            end
            S_LP01: begin
                lp_n     = 1'b1;
                ser_hi_z = 1'b1;
            end
            S_LP00:          ser_hi_z = 1'b1;
            S_PRE, S_POST:   ser_enable = 1'b1;
            S_HS: begin
                hs_rdy     = 1'b1;
                ser_enable = cont_clk | enable;
            end
            S_ULPS_ENT, S_WAKE: begin
                lp_p     = 1'b1;
                ser_hi_z = 1'b1;
            end
            S_ULPS: begin
                ser_hi_z    = 1'b1;
                ulps_active = 1'b1;
            end
            default: ;  // ZERO / TRAIL: serializer drives a static HS-0
        endcase
    end

endmodule

// File: tb/tb_clock_lane_fsm.sv
// Scoreboard bench for clock_lane_fsm: expected output vectors are queued when stimulus
// is driven and compared cycle by cycle; a second instance checks overridden timing.
module tb_clock_lane_fsm;

    typedef logic [6:0] obs_t;  // {lp_p, lp_n, ser_hi_z, ser_enable, hs_rdy, lane_idle, ulps_active}
    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    localparam obs_t V_LP11    = 7'b11_1_0_0_1_0;
    localparam obs_t V_LP01    = 7'b01_1_0_0_0_0;
    localparam obs_t V_LP00    = 7'b00_1_0_0_0_0;
    localparam obs_t V_ZERO    = 7'b00_0_0_0_0_0;
    localparam obs_t V_PRE     = 7'b00_0_1_0_0_0;
    localparam obs_t V_HS_EN   = 7'b00_0_1_1_0_0;
    localparam obs_t V_HS_NOEN = 7'b00_0_0_1_0_0;
    localparam obs_t V_POST    = 7'b00_0_1_0_0_0;
    localparam obs_t V_TRAIL   = 7'b00_0_0_0_0_0;
    localparam obs_t V_LP10    = 7'b10_1_0_0_0_0;
    localparam obs_t V_ULPS    = 7'b00_1_0_0_0_1;

    logic byte_clk = 1'b0;
    logic byte_rst = 1'b1;
    logic hs_req = 1'b0, enable = 1'b0, cont_clk = 1'b0, ulps_req = 1'b0;
    logic lp_p, lp_n, ser_hi_z, ser_enable, hs_rdy, lane_idle, ulps_active;
    logic hs_req2 = 1'b0, enable2 = 1'b1;
    logic lp_p2, lp_n2, ser_hi_z2, ser_enable2, hs_rdy2, lane_idle2, ulps_active2;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 byte_clk = ~byte_clk;

    clock_lane_fsm dut (
        .byte_clk(byte_clk), .byte_rst(byte_rst), .hs_req(hs_req), .enable(enable),
        .cont_clk(cont_clk), .ulps_req(ulps_req), .lp_p(lp_p), .lp_n(lp_n),
        .ser_hi_z(ser_hi_z), .ser_enable(ser_enable), .hs_rdy(hs_rdy),
        .lane_idle(lane_idle), .ulps_active(ulps_active)
    );

    clock_lane_fsm #(.ZERO_CYC(3), .PRE_CYC(1)) dut2 (
        .byte_clk(byte_clk), .byte_rst(byte_rst), .hs_req(hs_req2), .enable(enable2),
        .cont_clk(1'b0), .ulps_req(1'b0), .lp_p(lp_p2), .lp_n(lp_n2),
        .ser_hi_z(ser_hi_z2), .ser_enable(ser_enable2), .hs_rdy(hs_rdy2),
        .lane_idle(lane_idle2), .ulps_active(ulps_active2)
    );

    function automatic obs_t obs1();
        return {lp_p, lp_n, ser_hi_z, ser_enable, hs_rdy, lane_idle, ulps_active};
    endfunction

    function automatic obs_t obs2();
        return {lp_p2, lp_n2, ser_hi_z2, ser_enable2, hs_rdy2, lane_idle2, ulps_active2};
    endfunction

    task automatic push(input int n, input obs_t v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Entry from LP11 with default timing: LP01, LP00, 8 ZERO, 8 PRE.
    task automatic push_entry(input string pfx);
        push(1, V_LP01, {pfx, "_lp01"});
        push(1, V_LP00, {pfx, "_lp00"});
        push(8, V_ZERO, {pfx, "_zero"});
        push(8, V_PRE,  {pfx, "_pre"});
    endtask

    task automatic push_exit(input string pfx);
        push(8, V_POST,  {pfx, "_post"});
        push(8, V_TRAIL, {pfx, "_trail"});
        push(2, V_LP11,  {pfx, "_lp11"});
    endtask

    task automatic step();
        @(posedge byte_clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        push(1, V_LP11, "rst_held");
        #3;
        e = exp_q.pop_front();
        tests++;
        if (obs1() !== e.v) begin
            fails++;
            $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
        end
        step();
        byte_rst = 1'b0;
        push(3, V_LP11, "rst_idle");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    task automatic test_hs_entry_exit();
        exp_t e;
        hs_req = 1'b1;
        enable = 1'b1;
        push_entry("entry");
        push(4, V_HS_EN, "entry_hs");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        hs_req = 1'b0;
        push_exit("exit");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    task automatic test_enable_gating();
        exp_t e;
        hs_req = 1'b1;
        enable = 1'b0;
        push_entry("gate");
        push(2, V_HS_NOEN, "gate_hs_off");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        // ser_enable must follow enable within the same cycle, no clock edge in between.
        for (int i = 1; i <= 6; i++) begin
            enable = i[0];
            push(1, enable ? V_HS_EN : V_HS_NOEN, "gate_toggle");
            #2;
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        step();
        enable = 1'b0;
        hs_req = 1'b0;
        push_exit("gate_exit");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    task automatic test_cont_clk();
        exp_t e;
        cont_clk = 1'b1;
        hs_req   = 1'b0;
        enable   = 1'b0;
        push_entry("cont");
        push(6, V_HS_EN, "cont_hs");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        cont_clk = 1'b0;
        push_exit("cont_exit");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    task automatic test_ulps();
        exp_t e;
        ulps_req = 1'b1;
        push(1, V_LP10, "ulps_ent");
        push(5, V_ULPS, "ulps_hold");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        ulps_req = 1'b0;
        push(1000, V_LP10, "ulps_wake");
        push(2, V_LP11, "ulps_lp11");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        hs_req   = 1'b1;
        ulps_req = 1'b1;
        enable   = 1'b1;
        push_entry("prio");
        push(2, V_HS_EN, "prio_hs");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        hs_req   = 1'b0;
        ulps_req = 1'b0;
        push_exit("prio_exit");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    // hs_req re-raised during POST is ignored; LP11 then lasts exactly one cycle.
    task automatic test_back_to_back();
        exp_t e;
        int   k;
        hs_req = 1'b1;
        enable = 1'b1;
        push_entry("b2b");
        push(1, V_HS_EN, "b2b_hs");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        hs_req = 1'b0;
        push(8, V_POST, "b2b_post");
        push(8, V_TRAIL, "b2b_trail");
        push(1, V_LP11, "b2b_lp11");
        push_entry("b2b_re");
        push(2, V_HS_EN, "b2b_re_hs");
        k = 0;
        while (exp_q.size() > 0) begin
            step();
            k++;
            if (k == 3) hs_req = 1'b1;
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        hs_req = 1'b0;
        push_exit("b2b_exit");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    task automatic test_param_override();
        exp_t e;
        hs_req2 = 1'b1;
        push(1, V_LP01, "p_lp01");
        push(1, V_LP00, "p_lp00");
        push(3, V_ZERO, "p_zero");
        push(1, V_PRE,  "p_pre");
        push(2, V_HS_EN, "p_hs");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs2() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs2(), e.v);
            end
        end
        hs_req2 = 1'b0;
        push_exit("p_exit");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs2() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs2(), e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        hs_req = 1'b1;
        enable = 1'b1;
        push(1, V_LP01, "ar_lp01");
        push(1, V_LP00, "ar_lp00");
        push(8, V_ZERO, "ar_zero");
        push(4, V_PRE,  "ar_pre");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        // Mid-PRE reset between clock edges.
        #2;
        byte_rst = 1'b1;
        push(1, V_LP11, "ar_pre_rst");
        #1;
        e = exp_q.pop_front();
        tests++;
        if (obs1() !== e.v) begin
            fails++;
            $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
        end
        step();
        byte_rst = 1'b0;
        push_entry("ar_reentry");
        push(3, V_HS_EN, "ar_reentry_hs");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
        // Mid-HS reset: straight to LP11, no POST/TRAIL afterwards.
        #2;
        byte_rst = 1'b1;
        push(1, V_LP11, "ar_hs_rst");
        #1;
        e = exp_q.pop_front();
        tests++;
        if (obs1() !== e.v) begin
            fails++;
            $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
        end
        step();
        hs_req   = 1'b0;
        byte_rst = 1'b0;
        push(3, V_LP11, "ar_hs_idle");
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            tests++;
            if (obs1() !== e.v) begin
                fails++;
                $display("FAIL %s: got %b want %b", e.tag, obs1(), e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hs_entry_exit();
        test_enable_gating();
        test_cont_clk();
        test_ulps();
        test_priority();
        test_back_to_back();
        test_param_override();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
